winograd_pe: RTL and testbench

//   Winograd-domain processing element: element-wise multiply of a 6x6 transformed input tile (U)
//   by a 6x6 transformed filter tile (V), with registered result plus per-element output coordinates.

---
 rtl/winograd_pkg.sv | 15 +
 rtl/pe_mult.sv | 22 ++
 rtl/winograd_pe.sv | 86 ++++++++
 tb/tb_winograd_pe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// winograd_pkg: shared widths and tile typedefs for the Winograd processing element.
package winograd_pkg;
    localparam int TILE     = 6;
    localparam int DATA_W   = 14;
    localparam int WEIGHT_W = 12;
    localparam int RES_W    = 12;
    localparam int IDX_W    = 9;
    localparam int OD_W     = 8;
    localparam int SHIFT    = 0;

    typedef logic signed [DATA_W-1:0]   data_tile_t   [TILE][TILE];
    typedef logic signed [WEIGHT_W-1:0] weight_tile_t [TILE][TILE];
    typedef logic signed [RES_W-1:0]    result_tile_t [TILE][TILE];
    typedef logic signed [IDX_W-1:0]    index_tile_t  [TILE][TILE];
endpackage

// File: rtl/pe_mult.sv
// pe_mult: one tile element -- signed multiply, arithmetic shift, then narrow to RES_W.
// Narrowing clamps when PE_SATURATE_EN is defined, otherwise wraps.
module pe_mult
    import winograd_pkg::*;
(
    input  logic signed [DATA_W-1:0]   data,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [RES_W-1:0]    result
);
    localparam int P_W = DATA_W + WEIGHT_W;
    logic signed [P_W-1:0] p;
    logic signed [P_W-1:0] s;
    assign p = data * weight;
    assign s = p >>> SHIFT;
`ifdef PE_SATURATE_EN
    localparam logic signed [P_W-1:0] S_MAX = P_W'((1 <<< (RES_W - 1)) - 1);
    localparam logic signed [P_W-1:0] S_MIN = ~S_MAX;
    assign result = (s > S_MAX) ? RES_W'(S_MAX) : (s < S_MIN) ? RES_W'(S_MIN) : RES_W'(s);
`else
    assign result = RES_W'(s);
`endif
endmodule

// File: rtl/winograd_pe.sv
// winograd_pe: element-wise U*V tile multiply with per-element coordinates and systolic forwarding.
// Define PE_SATURATE_EN for clamped result narrowing (default: two's-complement wrap).
module winograd_pe
    import winograd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  data_tile_t         data_tile_i,
    input  logic               data_valid_i,
    input  logic [IDX_W-1:0]   data_x_index_i,
    input  logic [IDX_W-1:0]   data_y_index_i,
    input  weight_tile_t       weight_tile_i,
    input  logic               weight_valid_i,
    input  logic               weight_size_type_i,
    input  logic [OD_W-1:0]    weight_od_i,
    output result_tile_t       result_tile_o,
    output logic [OD_W-1:0]    result_od_o,
    output index_tile_t        result_i_o,
    output index_tile_t        result_j_o,
    output logic               result_valid_o,
    output data_tile_t         data_tile_reg_o,
    output logic               data_valid_o,
    output logic [IDX_W-1:0]   data_x_index_o,
    output logic [IDX_W-1:0]   data_y_index_o,
    output weight_tile_t       weight_tile_reg_o,
    output logic               weight_valid_o,
    output logic               weight_size_type_o,
    output logic [OD_W-1:0]    weight_od_o
);
    result_tile_t prod;
    index_tile_t  row_idx;
    index_tile_t  col_idx;
    logic         fire;

    assign fire = data_valid_i & weight_valid_i;

    for (genvar r = 0; r < TILE; r++) begin : g_r
        for (genvar c = 0; c < TILE; c++) begin : g_c
            pe_mult u_mult (
                .data   (data_tile_i[r][c]),
                .weight (weight_tile_i[r][c]),
                .result (prod[r][c])
            );
            assign row_idx[r][c] = data_x_index_i + IDX_W'(r);
            assign col_idx[r][c] = data_y_index_i + IDX_W'(c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_tile_o      <= '{default: '{default: '0}};
            result_i_o         <= '{default: '{default: '0}};
            result_j_o         <= '{default: '{default: '0}};
            result_od_o        <= '0;
            result_valid_o     <= 1'b0;
            data_tile_reg_o    <= '{default: '{default: '0}};
            data_valid_o       <= 1'b0;
            data_x_index_o     <= '0;
            data_y_index_o     <= '0;
            weight_tile_reg_o  <= '{default: '{default: '0}};
            weight_valid_o     <= 1'b0;
            weight_size_type_o <= 1'b0;
            weight_od_o        <= '0;
        end else begin
            result_valid_o <= fire;
            data_valid_o   <= data_valid_i;
            weight_valid_o <= weight_valid_i;
            if (fire) begin
                result_tile_o <= prod;
                result_i_o    <= row_idx;
                result_j_o    <= col_idx;
                result_od_o   <= weight_od_i;
            end
            if (data_valid_i) begin
                data_tile_reg_o <= data_tile_i;
                data_x_index_o  <= data_x_index_i;
                data_y_index_o  <= data_y_index_i;
            end
            if (weight_valid_i) begin
                weight_tile_reg_o  <= weight_tile_i;
                weight_size_type_o <= weight_size_type_i;
                weight_od_o        <= weight_od_i;
            end
        end
    end
endmodule

// File: tb/tb_winograd_pe.sv
// tb_winograd_pe: randomized self-checking bench for winograd_pe against an integer reference model.
module tb_winograd_pe;
    import winograd_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    data_tile_t         data_tile_i;
    logic               data_valid_i;
    logic [IDX_W-1:0]   data_x_index_i;
    logic [IDX_W-1:0]   data_y_index_i;
    weight_tile_t       weight_tile_i;
    logic               weight_valid_i;
    logic               weight_size_type_i;
    logic [OD_W-1:0]    weight_od_i;
    result_tile_t       result_tile_o;
    logic [OD_W-1:0]    result_od_o;
    index_tile_t        result_i_o;
    index_tile_t        result_j_o;
    logic               result_valid_o;
    data_tile_t         data_tile_reg_o;
    logic               data_valid_o;
    logic [IDX_W-1:0]   data_x_index_o;
    logic [IDX_W-1:0]   data_y_index_o;
    weight_tile_t       weight_tile_reg_o;
    logic               weight_valid_o;
    logic               weight_size_type_o;
    logic [OD_W-1:0]    weight_od_o;

    winograd_pe dut (
        .clk                (clk),
        .reset              (reset),
        .data_tile_i        (data_tile_i),
        .data_valid_i       (data_valid_i),
        .data_x_index_i     (data_x_index_i),
        .data_y_index_i     (data_y_index_i),
        .weight_tile_i      (weight_tile_i),
        .weight_valid_i     (weight_valid_i),
        .weight_size_type_i (weight_size_type_i),
        .weight_od_i        (weight_od_i),
        .result_tile_o      (result_tile_o),
        .result_od_o        (result_od_o),
        .result_i_o         (result_i_o),
        .result_j_o         (result_j_o),
        .result_valid_o     (result_valid_o),
        .data_tile_reg_o    (data_tile_reg_o),
        .data_valid_o       (data_valid_o),
        .data_x_index_o     (data_x_index_o),
        .data_y_index_o     (data_y_index_o),
        .weight_tile_reg_o  (weight_tile_reg_o),
        .weight_valid_o     (weight_valid_o),
        .weight_size_type_o (weight_size_type_o),
        .weight_od_o        (weight_od_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state, updated from the spec's rules at each rising edge.
    result_tile_t     exp_res;
    index_tile_t      exp_i;
    index_tile_t      exp_j;
    logic [OD_W-1:0]  exp_od;
    logic             exp_rv;
    data_tile_t       exp_dtile;
    logic             exp_dv;
    logic [IDX_W-1:0] exp_dx;
    logic [IDX_W-1:0] exp_dy;
    weight_tile_t     exp_wtile;
    logic             exp_wv;
    logic             exp_wst;
    logic [OD_W-1:0]  exp_wod;

    function automatic int narrow(int s);
        int lim = 1 << (RES_W - 1);
`ifdef PE_SATURATE_EN
        return (s > lim - 1) ? lim - 1 : (s < -lim) ? -lim : s;
`else
        int m = ((s % (2 * lim)) + 2 * lim) % (2 * lim);
        return (m >= lim) ? m - 2 * lim : m;
`endif
    endfunction

    function automatic int ref_elem(int d, int w);
        return narrow((d * w) >>> SHIFT);
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) begin
                exp_res[r][c] = '0; exp_i[r][c] = '0; exp_j[r][c] = '0;
                exp_dtile[r][c] = '0; exp_wtile[r][c] = '0;
            end
        exp_od = '0; exp_rv = 0; exp_dv = 0; exp_dx = '0; exp_dy = '0;
        exp_wv = 0; exp_wst = 0; exp_wod = '0;
    endfunction

    function automatic void model_step();
        exp_rv = data_valid_i & weight_valid_i;
        exp_dv = data_valid_i;
        exp_wv = weight_valid_i;
        if (exp_rv) begin
            for (int r = 0; r < TILE; r++)
                for (int c = 0; c < TILE; c++) begin
                    exp_res[r][c] = RES_W'(ref_elem(int'(data_tile_i[r][c]), int'(weight_tile_i[r][c])));
                    exp_i[r][c] = IDX_W'(int'(data_x_index_i) + r);
                    exp_j[r][c] = IDX_W'(int'(data_y_index_i) + c);
                end
            exp_od = weight_od_i;
        end
        if (data_valid_i) begin
            exp_dtile = data_tile_i; exp_dx = data_x_index_i; exp_dy = data_y_index_i;
        end
        if (weight_valid_i) begin
            exp_wtile = weight_tile_i; exp_wst = weight_size_type_i; exp_wod = weight_od_i;
        end
    endfunction

    function automatic logic [TILE*TILE*RES_W-1:0] pk_res(result_tile_t t);
        logic [TILE*TILE*RES_W-1:0] v = '0;
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) v[(r*TILE+c)*RES_W +: RES_W] = t[r][c];
        return v;
    endfunction

    function automatic logic [TILE*TILE*IDX_W-1:0] pk_idx(index_tile_t t);
        logic [TILE*TILE*IDX_W-1:0] v = '0;
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) v[(r*TILE+c)*IDX_W +: IDX_W] = t[r][c];
        return v;
    endfunction

    function automatic logic [TILE*TILE*DATA_W-1:0] pk_data(data_tile_t t);
        logic [TILE*TILE*DATA_W-1:0] v = '0;
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) v[(r*TILE+c)*DATA_W +: DATA_W] = t[r][c];
        return v;
    endfunction

    function automatic logic [TILE*TILE*WEIGHT_W-1:0] pk_wt(weight_tile_t t);
        logic [TILE*TILE*WEIGHT_W-1:0] v = '0;
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) v[(r*TILE+c)*WEIGHT_W +: WEIGHT_W] = t[r][c];
        return v;
    endfunction

    function automatic logic any_out();
        return |{pk_res(result_tile_o), pk_idx(result_i_o), pk_idx(result_j_o), result_od_o,
                 result_valid_o, pk_data(data_tile_reg_o), data_valid_o, data_x_index_o,
                 data_y_index_o, pk_wt(weight_tile_reg_o), weight_valid_o, weight_size_type_o,
                 weight_od_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic fill(int d, int w);
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) begin
                data_tile_i[r][c] = DATA_W'(d);
                weight_tile_i[r][c] = WEIGHT_W'(w);
            end
    endtask

    task automatic rand_inputs();
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) begin
                data_tile_i[r][c] = DATA_W'($urandom);
                weight_tile_i[r][c] = WEIGHT_W'($urandom);
            end
        data_x_index_i = IDX_W'($urandom);
        data_y_index_i = IDX_W'($urandom);
        weight_size_type_i = 1'($urandom);
        weight_od_i = OD_W'($urandom);
    endtask

    task automatic test_reset();
        reset = 1; data_valid_i = 0; weight_valid_i = 0;
        fill(0, 0);
        data_x_index_i = '0; data_y_index_i = '0; weight_size_type_i = 0; weight_od_i = '0;
        model_reset();
        #12;
        checks++;
        if (any_out() !== 1'b0) begin
            errors++; $display("FAIL reset_state: outputs nonzero=%b, required 0", any_out());
        end
        @(negedge clk); reset = 0;
        tick(); tick();
        checks++;
        if (any_out() !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: outputs nonzero=%b, required 0", any_out());
        end
    endtask

    task automatic test_basic();
        int bad = 0;
        fill(2, 3);
        data_x_index_i = 10; data_y_index_i = 15; weight_od_i = 3; weight_size_type_i = 1;
        data_valid_i = 1; weight_valid_i = 1;
        tick();
        data_valid_i = 0; weight_valid_i = 0;
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) if (result_tile_o[r][c] !== 12'sd6) bad++;
        checks++;
        if (result_valid_o !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b, required 1", result_valid_o);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL basic_result: %0d elements differ from 6", bad);
        end
        checks++;
        if (result_od_o !== 8'd3) begin
            errors++; $display("FAIL basic_od: got %0d, required 3", result_od_o);
        end
        checks++;
        if (result_i_o[2][3] !== 9'sd12 || result_j_o[2][3] !== 9'sd18) begin
            errors++; $display("FAIL basic_coord: i=%0d j=%0d, required 12 18", result_i_o[2][3], result_j_o[2][3]);
        end
        checks++;
        if (pk_idx(result_i_o) !== pk_idx(exp_i) || pk_idx(result_j_o) !== pk_idx(exp_j)) begin
            errors++; $display("FAIL basic_coord_tiles: i=%h j=%h", pk_idx(result_i_o), pk_idx(result_j_o));
        end
        tick();
        checks++;
        if (result_valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: got %b, required 0", result_valid_o);
        end
        checks++;
        if (pk_res(result_tile_o) !== pk_res(exp_res) || result_od_o !== exp_od) begin
            errors++; $display("FAIL basic_hold: got %h, required %h", pk_res(result_tile_o), pk_res(exp_res));
        end
    endtask

    task automatic test_data_only();
        int bad = 0;
        fill(-5, 7);
        data_valid_i = 1; weight_valid_i = 1;
        tick();
        for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++) if (result_tile_o[r][c] !== -12'sd35) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL neg_result: %0d elements differ from -35", bad);
        end
        fill(9, 1);
        weight_valid_i = 0; weight_od_i = 8'd77;
        tick();
        data_valid_i = 0;
        checks++;
        if (result_valid_o !== 1'b0 || data_valid_o !== 1'b1 || weight_valid_o !== 1'b0) begin
            errors++; $display("FAIL data_only_valids: rv=%b dv=%b wv=%b, required 0 1 0",
                               result_valid_o, data_valid_o, weight_valid_o);
        end
        checks++;
        if (pk_data(data_tile_reg_o) !== pk_data(exp_dtile) || data_tile_reg_o[5][5] !== 14'sd9) begin
            errors++; $display("FAIL data_only_fwd: got %h, required %h", pk_data(data_tile_reg_o), pk_data(exp_dtile));
        end
        checks++;
        if (weight_tile_reg_o[0][0] !== 12'sd7 || weight_od_o !== exp_wod) begin
            errors++; $display("FAIL data_only_weight_hold: w=%0d od=%0d, required 7 %0d",
                               weight_tile_reg_o[0][0], weight_od_o, exp_wod);
        end
        checks++;
        if (result_tile_o[3][3] !== -12'sd35) begin
            errors++; $display("FAIL data_only_result_hold: got %0d, required -35", result_tile_o[3][3]);
        end
    endtask

    task automatic test_boundary();
        logic signed [RES_W-1:0] want_hi, want_lo;
`ifdef PE_SATURATE_EN
        want_hi = 12'sd2047; want_lo = -12'sd2048;
`else
        want_hi = -12'sd2047; want_lo = 12'sd0;
`endif
        fill(8191, 2047);
        data_valid_i = 1; weight_valid_i = 1;
        tick();
        checks++;
        if (result_tile_o[0][0] !== want_hi || pk_res(result_tile_o) !== pk_res(exp_res)) begin
            errors++; $display("FAIL boundary_max: got %0d, required %0d", result_tile_o[0][0], want_hi);
        end
        fill(-8192, 2047);
        tick();
        data_valid_i = 0; weight_valid_i = 0;
        checks++;
        if (result_tile_o[5][5] !== want_lo || pk_res(result_tile_o) !== pk_res(exp_res)) begin
            errors++; $display("FAIL boundary_min: got %0d, required %0d", result_tile_o[5][5], want_lo);
        end
    endtask

    task automatic test_back_to_back();
        data_valid_i = 1; weight_valid_i = 1;
        for (int k = 0; k < 4; k++) begin
            rand_inputs();
            tick();
            checks++;
            if (result_valid_o !== 1'b1 || pk_res(result_tile_o) !== pk_res(exp_res) || result_od_o !== exp_od) begin
                errors++; $display("FAIL b2b_cycle%0d: rv=%b od=%0d res=%h, required 1 %0d %h", k,
                                   result_valid_o, result_od_o, pk_res(result_tile_o), exp_od, pk_res(exp_res));
            end
        end
        rand_inputs();
        #2 reset = 1;
        #1;
        model_reset();
        checks++;
        if (any_out() !== 1'b0) begin
            errors++; $display("FAIL async_reset: outputs nonzero=%b, required 0", any_out());
        end
        data_valid_i = 0; weight_valid_i = 0;
        @(negedge clk); reset = 0;
        tick();
        checks++;
        if (result_valid_o !== 1'b0 || any_out() !== 1'b0) begin
            errors++; $display("FAIL reset_no_stale: rv=%b nonzero=%b, required 0 0", result_valid_o, any_out());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            rand_inputs();
            data_valid_i = 1'($urandom);
            weight_valid_i = 1'($urandom);
            tick();
            checks++;
            if (result_valid_o !== exp_rv || pk_res(result_tile_o) !== pk_res(exp_res) || result_od_o !== exp_od ||
                pk_idx(result_i_o) !== pk_idx(exp_i) || pk_idx(result_j_o) !== pk_idx(exp_j)) begin
                errors++; $display("FAIL rand_result_%0d: rv=%b od=%0d res=%h, required %b %0d %h", k,
                                   result_valid_o, result_od_o, pk_res(result_tile_o), exp_rv, exp_od, pk_res(exp_res));
            end
            checks++;
            if (data_valid_o !== exp_dv || pk_data(data_tile_reg_o) !== pk_data(exp_dtile) ||
                data_x_index_o !== exp_dx || data_y_index_o !== exp_dy) begin
                errors++; $display("FAIL rand_data_fwd_%0d: dv=%b x=%0d y=%0d, required %b %0d %0d", k,
                                   data_valid_o, data_x_index_o, data_y_index_o, exp_dv, exp_dx, exp_dy);
            end
            checks++;
            if (weight_valid_o !== exp_wv || pk_wt(weight_tile_reg_o) !== pk_wt(exp_wtile) ||
                weight_size_type_o !== exp_wst || weight_od_o !== exp_wod) begin
                errors++; $display("FAIL rand_weight_fwd_%0d: wv=%b st=%b od=%0d, required %b %b %0d", k,
                                   weight_valid_o, weight_size_type_o, weight_od_o, exp_wv, exp_wst, exp_wod);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_data_only();
        test_boundary();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
